// File: rtl/sdram_host_arbiter.sv
// Two-client round-robin front end for the SDRAM controller command port.
// Read responses are routed back to the issuing client through an in-order tag FIFO.
//
// state  | meaning
// IDLE   | arbitrate; accept one eligible request into the holding registers
// ISSUE  | drive wr_enable/rd_enable until the controller is not busy
// GAP    | one dead cycle while the controller's registered busy catches up
// WAIT   | wait for busy to drop before arbitrating again
module sdram_host_arbiter #(
  parameter int ROW_WIDTH   = 13,
  parameter int COL_WIDTH   = 9,
  parameter int BANK_WIDTH  = 2,
  parameter int HADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH,
  parameter int RD_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_0,
  input  logic                   req_valid_1,
  output logic                   req_ready_0,
  output logic                   req_ready_1,
  input  logic                   req_we_0,
  input  logic                   req_we_1,
  input  logic [HADDR_WIDTH-1:0] req_addr_0,
  input  logic [HADDR_WIDTH-1:0] req_addr_1,
  input  logic [15:0]            req_wdata_0,
  input  logic [15:0]            req_wdata_1,
  output logic                   rsp_valid_0,
  output logic                   rsp_valid_1,
  output logic [15:0]            rsp_data,
  output logic [HADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]            wr_data,
  output logic                   wr_enable,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_enable,
  input  logic                   busy,
  input  logic [15:0]            rd_data,
  input  logic                   rd_ready,
  output logic                   err_orphan
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT} state_t;

  state_t state, state_nxt;
  logic last_grant, hold_we, hold_id;

  logic [RD_DEPTH-1:0] tags;
  logic [PW-1:0]       wptr, rptr;
  logic [CW-1:0]       count;

  logic fifo_full, fifo_empty;
  logic elig_0, elig_1, grant_any, grant_id, accept;
  logic push, pop, head_tag;
  logic                   sel_we;
  logic [HADDR_WIDTH-1:0] sel_addr;
  logic [15:0]            sel_wdata;

  assign fifo_full  = (count == CW'(RD_DEPTH));
  assign fifo_empty = (count == '0);

  assign elig_0    = req_valid_0 && (req_we_0 || !fifo_full);
  assign elig_1    = req_valid_1 && (req_we_1 || !fifo_full);
  assign grant_any = elig_0 || elig_1;
  assign grant_id  = (elig_0 && elig_1) ? ~last_grant : elig_1;
  assign accept    = req_ready_0 || req_ready_1;

  assign sel_we    = grant_id ? req_we_1    : req_we_0;
  assign sel_addr  = grant_id ? req_addr_1  : req_addr_0;
  assign sel_wdata = grant_id ? req_wdata_1 : req_wdata_0;

  always_comb begin
    state_nxt   = state;
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    wr_enable   = 1'b0;
    rd_enable   = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          req_ready_0 = ~grant_id;
          req_ready_1 = grant_id;
          state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wr_enable = hold_we;
        rd_enable = ~hold_we;
        if (!busy) state_nxt = S_GAP;
      end
      S_GAP:   state_nxt = S_WAIT;
      S_WAIT:  if (!busy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      hold_we    <= 1'b0;
      hold_id    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_addr    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant_id;
        hold_we    <= sel_we;
        hold_id    <= grant_id;
        if (sel_we) begin
          wr_addr <= sel_addr;
          wr_data <= sel_wdata;
        end else begin
          rd_addr <= sel_addr;
        end
      end
    end
  end

  // An empty FIFO with a same-edge push hands the pushed tag straight to the pop.
  assign push     = (state == S_ISSUE) && !busy && !hold_we;
  assign pop      = rd_ready && (!fifo_empty || push);
  assign head_tag = fifo_empty ? hold_id : tags[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags        <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_data    <= '0;
      err_orphan  <= 1'b0;
    end else begin
      if (push) begin
        tags[wptr] <= hold_id;
        wptr       <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      rsp_valid_0 <= pop && !head_tag;
      rsp_valid_1 <= pop && head_tag;
      if (pop) rsp_data <= rd_data;
      if (rd_ready && !pop) err_orphan <= 1'b1;
    end
  end

endmodule
